// File: rtl/bpu_predictor.sv
// Branch predictor feeding the PC stage: direct-mapped table of 2-bit counters and offsets.
// A sweep after reset clears the table before lookups and updates are enabled.
module bpu_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   output logic        pred_taken,
   output logic [31:0] pred_imm,
   output logic        pred_hit,
   output logic        ready,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_imm
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_MSB = INDEX_BITS + TAG_BITS - 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t                state;
   logic [INDEX_BITS-1:0] sweep_ptr;

   logic                  tbl_valid [ENTRIES];
   logic [TAG_BITS-1:0]   tbl_tag   [ENTRIES];
   logic [1:0]            tbl_ctr   [ENTRIES];
   logic [31:0]           tbl_imm   [ENTRIES];

   logic [INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]   lk_tag;
   logic                  lk_hit;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  upd_hit;

   // Upper PC bits are deliberately ignored; aliasing across them is accepted.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_in[31:TAG_MSB+1], upd_pc[31:TAG_MSB+1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         sweep_ptr <= '0;
      end else if (state == INIT) begin
         sweep_ptr <= sweep_ptr + INDEX_BITS'(1);
         if (sweep_ptr == '1) begin
            state <= RUN;
         end
      end
   end

   assign ready = (state == RUN);

   assign upd_idx = upd_pc[INDEX_BITS-1:0];
   assign upd_tag = upd_pc[TAG_MSB:INDEX_BITS];
   assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

   // Table storage is never reset directly; the INIT sweep clears one entry per edge.
   always_ff @(posedge clk) begin
      if (!reset && state == INIT) begin
         tbl_valid[sweep_ptr] <= 1'b0;
         tbl_tag[sweep_ptr]   <= '0;
         tbl_ctr[sweep_ptr]   <= 2'b01;
         tbl_imm[sweep_ptr]   <= '0;
      end else if (!reset && state == RUN && upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (tbl_ctr[upd_idx] != 2'b11) begin
                  tbl_ctr[upd_idx] <= tbl_ctr[upd_idx] + 2'd1;
               end
               tbl_imm[upd_idx] <= upd_imm;
            end else if (tbl_ctr[upd_idx] != 2'b00) begin
               tbl_ctr[upd_idx] <= tbl_ctr[upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            tbl_valid[upd_idx] <= 1'b1;
            tbl_tag[upd_idx]   <= upd_tag;
            tbl_ctr[upd_idx]   <= 2'b10;
            tbl_imm[upd_idx]   <= upd_imm;
         end
      end
   end

   // Zero-latency lookup sees pre-update contents when an update targets the same entry.
   assign lk_idx     = pc_in[INDEX_BITS-1:0];
   assign lk_tag     = pc_in[TAG_MSB:INDEX_BITS];
   assign lk_hit     = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
   assign pred_hit   = ready && lk_hit;
   assign pred_taken = pred_hit && tbl_ctr[lk_idx][1];
   assign pred_imm   = pred_taken ? tbl_imm[lk_idx] : 32'd0;

endmodule

// File: tb/tb_bpu_predictor.sv
// Scoreboard bench for bpu_predictor: a behavioural table model pushes expected
// lookup results each cycle, which are popped and compared mid-cycle.
module tb_bpu_predictor;

   localparam int ENTRIES = 64;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in;
   logic        pred_taken;
   logic [31:0] pred_imm;
   logic        pred_hit;
   logic        ready;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_imm;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          known;
      logic        taken;
      logic [31:0] imm;
      logic        hit;
      logic        rdy;
      string       what;
   } exp_t;

   exp_t exp_q[$];

   bit        m_known = 0;
   int        m_cnt   = 0;
   bit        m_valid [ENTRIES];
   bit [7:0]  m_tag   [ENTRIES];
   bit [1:0]  m_ctr   [ENTRIES];
   bit [31:0] m_imm   [ENTRIES];

   bpu_predictor dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .pred_taken (pred_taken),
      .pred_imm   (pred_imm),
      .pred_hit   (pred_hit),
      .ready      (ready),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_imm    (upd_imm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model the effect of one rising edge; reset invalidates everything at once.
   function automatic void modelEdge(input bit rst, input bit uv, input logic [31:0] upc,
                                     input bit ut, input logic [31:0] uimm);
      int idx;
      bit [7:0] tg;
      if (rst) begin
         m_known = 1;
         m_cnt   = 0;
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      end else if (m_cnt < ENTRIES) begin
         m_cnt++;
      end else if (uv) begin
         idx = int'(upc[5:0]);
         tg  = upc[13:6];
         if (m_valid[idx] && m_tag[idx] == tg) begin
            if (ut) begin
               m_ctr[idx] = (m_ctr[idx] == 2'd3) ? 2'd3 : m_ctr[idx] + 2'd1;
               m_imm[idx] = uimm;
            end else begin
               m_ctr[idx] = (m_ctr[idx] == 2'd0) ? 2'd0 : m_ctr[idx] - 2'd1;
            end
         end else if (ut) begin
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_ctr[idx]   = 2'd2;
            m_imm[idx]   = uimm;
         end
      end
   endfunction

   task automatic applyStimulus(input string what, input bit rst, input logic [31:0] pc,
                                input bit uv, input logic [31:0] upc, input bit ut,
                                input logic [31:0] uimm);
      exp_t e;
      exp_t got;
      int idx;
      reset     = rst;
      pc_in     = pc;
      upd_valid = uv;
      upd_pc    = upc;
      upd_taken = ut;
      upd_imm   = uimm;
      idx       = int'(pc[5:0]);
      e.known   = m_known;
      e.what    = what;
      e.rdy     = (m_cnt == ENTRIES);
      e.hit     = e.rdy && m_valid[idx] && (m_tag[idx] == pc[13:6]);
      e.taken   = e.hit && m_ctr[idx][1];
      e.imm     = e.taken ? m_imm[idx] : 32'd0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      if (got.known) begin
         checkOutput({got.what, ".ready"}, 32'(ready),      32'(got.rdy));
         checkOutput({got.what, ".hit"},   32'(pred_hit),   32'(got.hit));
         checkOutput({got.what, ".taken"}, 32'(pred_taken), 32'(got.taken));
         checkOutput({got.what, ".imm"},   pred_imm,        got.imm);
      end
      @(posedge clk);
      modelEdge(rst, uv, upc, ut, uimm);
      #1;
   endtask

   initial begin
      logic [31:0] rpc;
      logic [31:0] rupc;
      reset     = 1'b1;
      pc_in     = '0;
      upd_valid = 1'b0;
      upd_pc    = '0;
      upd_taken = 1'b0;
      upd_imm   = '0;
      @(posedge clk);
      #1;

      applyStimulus("rst", 1, 32'h105, 1, 32'h105, 1, 32'h20);
      applyStimulus("rst", 1, 32'h105, 1, 32'h105, 1, 32'h20);
      for (int i = 0; i < ENTRIES; i++)
         applyStimulus("sweep", 0, $urandom, 1, 32'h105, 1, $urandom);

      applyStimulus("alloc",    0, 32'h0,   1, 32'h105, 1, 32'h20);
      applyStimulus("hit105",   0, 32'h105, 0, 32'h0,   0, 32'h0);
      applyStimulus("alias205", 0, 32'h205, 0, 32'h0,   0, 32'h0);

      applyStimulus("tk1",  0, 32'h105, 1, 32'h105, 1, 32'h20);
      applyStimulus("tk2",  0, 32'h105, 1, 32'h105, 1, 32'h20);
      applyStimulus("sat3", 0, 32'h105, 1, 32'h105, 0, 32'h99);
      applyStimulus("nt1",  0, 32'h105, 1, 32'h105, 0, 32'h0);
      applyStimulus("nt2",  0, 32'h105, 1, 32'h105, 0, 32'h0);
      applyStimulus("nt3",  0, 32'h105, 1, 32'h105, 0, 32'h0);
      applyStimulus("nt4",  0, 32'h105, 1, 32'h105, 1, 32'h30);
      applyStimulus("sat0", 0, 32'h105, 0, 32'h0,   0, 32'h0);

      applyStimulus("nt33",   0, 32'h0,  1, 32'h33, 0, 32'h44);
      applyStimulus("look33", 0, 32'h33, 0, 32'h0,  0, 32'h0);

      applyStimulus("haz",     0, 32'h40, 1, 32'h40, 1, 32'h7);
      applyStimulus("haznext", 0, 32'h40, 0, 32'h0,  0, 32'h0);

      applyStimulus("rst2", 1, 32'h105, 1, 32'h105, 1, 32'h20);
      for (int i = 0; i < 30; i++)
         applyStimulus("sweep2", 0, 32'h105, 1, 32'h105, 1, 32'h20);
      applyStimulus("rst3", 1, 32'h105, 1, 32'h105, 1, 32'h20);
      for (int i = 0; i < ENTRIES; i++)
         applyStimulus("sweep3", 0, 32'h105, 1, 32'h105, 1, 32'h20);
      applyStimulus("post105", 0, 32'h105, 0, 32'h0, 0, 32'h0);

      // Dense traffic over a few indices and tags to exercise counters and replacement.
      for (int i = 0; i < 300; i++) begin
         rpc  = ($urandom_range(0, 3) << 6) | $urandom_range(0, 7);
         rupc = ($urandom_range(0, 3) << 6) | $urandom_range(0, 7);
         applyStimulus("rand", 0, rpc, 1'($urandom_range(0, 1)), rupc,
                       1'($urandom_range(0, 1)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bpu_predictor.md
# bpu_predictor

- Branch prediction stage directly upstream of the program counter.
- Each cycle it looks up the current PC in a direct-mapped table of 2-bit saturating counters and branch offsets.
- It drives the PC's take-branch select and immediate offset from that lookup.
- Resolved branches from execute update the table; after reset, a sweep FSM clears the table before predictions are enabled.

## Interface
- INDEX_BITS, default 6: table has 2^INDEX_BITS entries, indexed by pc[INDEX_BITS-1:0].
- TAG_BITS, default 8: tag is pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS].
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- pc_in  in  32  current PC (word address, increments by 1).
- pred_taken  out  1  predicted taken; feeds PC branch select.
- pred_imm  out  32  predicted offset; feeds PC immediate.
- pred_hit  out  1  lookup hit a valid entry with matching tag.
- ready  out  1  table initialised; predictions and updates active.
- upd_valid  in  1  resolved-branch update strobe.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_imm  in  32  actual offset; meaningful when upd_taken=1.

## Operation
- Entry fields: valid (1), tag (TAG_BITS), ctr (2), imm (32).
- FSM states:
  - INIT: clearing sweep active.
  - RUN: normal operation.
- reset=1 at an edge: state<=INIT, sweep_ptr<=0. Applies from any state, including mid-sweep, which restarts the sweep.
- INIT, reset=0 at an edge:
  - Clear entry[sweep_ptr]: valid=0, ctr=01, tag=0, imm=0.
  - sweep_ptr<=sweep_ptr+1.
  - If sweep_ptr==2^INDEX_BITS-1, state<=RUN.
  - Updates are ignored.
- Lookup is combinational, from pc_in to the current table contents:
  - hit = valid && tag match.
  - pred_taken = ready && hit && ctr[1].
  - pred_imm = pred_taken ? entry.imm : 0.
  - pred_hit = ready && hit.
- Update applies only in RUN with upd_valid=1, to the entry at upd_pc's index:
  - Hit, upd_taken=1: ctr saturating increment (11 stays 11); imm<=upd_imm.
  - Hit, upd_taken=0: ctr saturating decrement (00 stays 00); imm unchanged.
  - Miss (invalid or tag mismatch), upd_taken=1: allocate or replace; valid=1, tag=upd_pc tag, ctr=10, imm=upd_imm.
  - Miss, upd_taken=0: no change.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff ctr[1].
- pc_in bits above INDEX_BITS+TAG_BITS are not compared; aliasing is accepted.
- Arithmetic is 32-bit; imm is stored and driven verbatim, with no sign handling.

## Timing
- Reset values: ready=0, pred_taken=0, pred_imm=0, pred_hit=0. All four are held at these values for the whole of INIT.
- Sweep length is exactly 2^INDEX_BITS edges after reset deasserts. Default: ready=1 after the 64th edge with reset=0.
- Lookup has zero latency: outputs follow pc_in in the same cycle.
- An update written at edge N is visible to lookups from cycle N+1.
- Simultaneous lookup and update to the same index: the lookup returns pre-update contents.
- Back-to-back updates to one entry are applied in order, one per edge; the counter saturates correctly across consecutive updates.
- An update with upd_valid=1 in the same cycle as reset=1 is discarded.

## Test plan
- Reset sweep: assert reset 2 cycles, release. Expect ready=0 for 64 edges and 1 after the 64th. Expect pred_taken=0 and pred_hit=0 for every pc_in during the sweep.
- Allocate and predict:
  - After ready, update upd_pc=0x105, taken=1, imm=0x20.
  - Next cycle, pc_in=0x105 gives pred_hit=1, pred_taken=1, pred_imm=0x20.
  - pc_in=0x205 (same index, different tag) gives pred_hit=0, pred_taken=0.
- Saturation:
  - Two taken updates to 0x105 bring ctr to 11, holding at 11.
  - One not-taken update: still taken (10).
  - Second not-taken update: pred_taken=0, pred_hit=1, pred_imm=0.
  - Two further not-taken updates: ctr holds at 00.
- Not-taken miss: update upd_pc=0x33, taken=0 on an empty entry. Expect pc_in=0x33 to give pred_hit=0 and no allocation.
- Same-cycle hazard: pc_in=0x40 with update upd_pc=0x40, taken=1, imm=7 in the same cycle. That cycle gives pred_hit=0; the next cycle gives pred_taken=1, pred_imm=7.
- Reset mid-operation:
  - Assert reset in RUN at sweep position 30 of a second sweep, then release.
  - Expect the full 64-edge sweep to restart.
  - After ready, the previously trained PC 0x105 gives pred_hit=0.
